// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module : cpu_types_pkg
//  Desc   : Shared CPU types: the data word, the instruction-cache address
//           overlay and frame layout, and the I-cache FSM state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAGW = 30 - ICACHE_IDXW;

    // Address overlay and frame layout for the default geometry
    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_direct.sv
// ============================================================================
//  Module : icache_direct
//  Desc   : Direct-mapped, one-word-per-line instruction cache between the
//           fetch stage and memory control. Optional ICACHE_PERF_EN macro adds
//           saturating hit/miss counters.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iinv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
   ,output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    icache_state_t    state;
    icache_state_t    next_state;
    logic [29:0]      fill_word;
    logic [SETS-1:0]  valid;
    logic [TAGW-1:0]  tag_arr  [SETS];
    word_t            data_arr [SETS];

    logic [IDXW-1:0]  req_idx;
    logic [TAGW-1:0]  req_tag;
    logic [IDXW-1:0]  fill_idx;
    logic [TAGW-1:0]  fill_tag;
    logic             lookup_hit;
    logic             start_fill;
    logic             fill_we;
    logic             unused_bits;

    assign req_idx     = imemaddr[IDXW+1:2];
    assign req_tag     = imemaddr[31:IDXW+2];
    assign fill_idx    = fill_word[IDXW-1:0];
    assign fill_tag    = fill_word[29:IDXW];
    assign unused_bits = &{1'b0, imemaddr[1:0]};

    // A pending invalidate masks the hit so a stale line is never returned
    assign lookup_hit = imemREN && (state == IDLE) && !iinv
                        && valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign ihit       = lookup_hit;
    assign imemload   = lookup_hit ? data_arr[req_idx] : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        start_fill = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN && !lookup_hit && !iinv) begin
                    next_state = FETCH;
                    start_fill = 1'b1;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {fill_word, 2'b00};
                if (iinv) begin
                    next_state = IDLE;
                end else if (!iwait) begin
                    fill_we    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fill_word <= '0;
            valid     <= '0;
        end else begin
            if (start_fill) begin
                fill_word <= imemaddr[31:2];
            end
            if (iinv) begin
                valid <= '0;
            end else if (fill_we) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits alone qualify them
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (lookup_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'h1;
            end
            if (start_fill && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'h1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_direct.sv
// ============================================================================
//  Module : tb_icache_direct
//  Desc   : Self-checking bench for icache_direct: directed scenarios plus
//           randomized accesses against a line-level reference model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iinv;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: one entry per set, indexed by word address modulo 16
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    always #5 CLK = ~CLK;

    icache_direct #(.SETS(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iinv      (iinv),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload)
`ifdef ICACHE_PERF_EN
       ,.hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk_counts();
`ifdef ICACHE_PERF_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
`endif
    endtask

    // One fetch request held until its word is delivered; memory answers after 'waits' busy cycles
    task automatic access(input logic [31:0] addr, input int waits);
        int          idx;
        logic [25:0] tag;
        logic        exp_hit;
        logic [31:0] word_addr;
        idx       = (addr >> 2) % 16;
        tag       = addr[31:6];
        word_addr = {addr[31:2], 2'b00};
        exp_hit   = m_valid[idx] && (m_tag[idx] == tag);
        imemREN = 1'b1; imemaddr = addr; iinv = 1'b0; iwait = 1'b1; iload = $urandom;
        @(negedge CLK);
        chk("lookup_ihit", ihit, exp_hit);
        chk("lookup_load", imemload, exp_hit ? m_data[idx] : 32'h0);
        chk("idle_iREN", iREN, 0);
        chk("idle_iaddr", iaddr, 0);
        if (exp_hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            for (int k = 0; k <= waits; k++) begin
                @(posedge CLK); #1;
                iwait = (k < waits);
                iload = (k == waits) ? mem_word(word_addr) : $urandom;
                @(negedge CLK);
                chk("fetch_iREN", iREN, 1);
                chk("fetch_iaddr", iaddr, word_addr);
                chk("fetch_ihit", ihit, 0);
            end
            @(posedge CLK); #1;
            iwait = 1'b1;
            m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = mem_word(word_addr);
            @(negedge CLK);
            chk("fill_ihit", ihit, 1);
            chk("fill_load", imemload, m_data[idx]);
            chk("fill_iREN", iREN, 0);
            exp_hits++;
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk_counts();
        @(posedge CLK); #1;
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iinv = 1'b0; iwait = 1'b1; iload = 32'h0;
        model_clear();
        @(negedge CLK);
        chk("rst_ihit", ihit, 0);
        chk("rst_imemload", imemload, 0);
        chk("rst_iREN", iREN, 0);
        chk("rst_iaddr", iaddr, 0);
        chk_counts();
        @(posedge CLK); #1;
        imemREN = 1'b0;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Cold miss, hits, offset-insensitive hit, conflict on set 0
        access(32'h40, 3);
        access(32'h40, 0);
        access(32'h42, 0);
        access(32'h80, 2);
        access(32'h40, 1);
        access(32'h44, 0);

        // Invalidate on a would-be hit masks ihit
        imemREN = 1'b1; imemaddr = 32'h44; iinv = 1'b1;
        @(negedge CLK);
        chk("inv_ihit", ihit, 0);
        chk("inv_iREN", iREN, 0);
        @(posedge CLK); #1;
        iinv = 1'b0; imemREN = 1'b0;
        model_clear();
        access(32'h44, 0);

        // Invalidate on the 2nd FETCH cycle coinciding with completion: nothing written
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        @(negedge CLK);
        chk("inv_fill_miss", ihit, 0);
        exp_misses++;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("inv_fill_iREN1", iREN, 1);
        @(posedge CLK); #1;
        iinv = 1'b1; iwait = 1'b0; iload = mem_word(32'h100); imemREN = 1'b0;
        @(negedge CLK);
        chk("inv_fill_iREN2", iREN, 1);
        chk("inv_fill_iaddr", iaddr, 32'h100);
        @(posedge CLK); #1;
        iinv = 1'b0; iwait = 1'b1;
        model_clear();
        @(negedge CLK);
        chk("inv_fill_idle", iREN, 0);
        @(posedge CLK); #1;
        access(32'h100, 1);
        access(32'h44, 0);
        access(32'h40, 2);

        // Reset asserted mid-FETCH acts immediately
        imemREN = 1'b1; imemaddr = 32'h48; iwait = 1'b1;
        @(negedge CLK);
        chk("rstf_miss", ihit, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rstf_iREN_before", iREN, 1);
        #1 nRST = 1'b0;
        #1;
        chk("rstf_iREN", iREN, 0);
        chk("rstf_iaddr", iaddr, 0);
        chk("rstf_ihit", ihit, 0);
        model_clear();
        exp_hits = 0; exp_misses = 0;
        chk_counts();
        #1 nRST = 1'b1; imemREN = 1'b0;
        @(posedge CLK); #1;
        access(32'h40, 0);
        access(32'h44, 1);

        // Randomized accesses over a few tags per set, with occasional idle invalidates
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                iinv = 1'b1;
                @(posedge CLK); #1;
                iinv = 1'b0;
                model_clear();
            end
            access(a, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
